mips_mc_ctrl: RTL and testbench
===============================

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

Interface
REQ-001 Parameter MEM_WAIT, default 0, SHALL set the extra wait cycles per memory-access state (range 0..15).
REQ-002 Parameter WAIT_W, default 4, SHALL set the wait-counter width; MEM_WAIT SHALL fit in WAIT_W bits.
REQ-003 clk  in  1  sole clock, all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 op  in  6  opcode of the instruction register.
REQ-006 funct-independent outputs, each 1 bit: pcwrite, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, zeroext.
REQ-007 alusrcb, pcsrc, aluop, branch  out  2 each  (branch: 00 none, 01 beq, 10 bne).
REQ-008 state  out  4  current state code, for debug.
REQ-009 instr_done  out  1  one-cycle pulse on the last cycle of every instruction.
REQ-010 trap  out  1  illegal-opcode indication (see Configuration).

Function
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQEX, BNEEX, ADDIEX, ORIEX, IMMWB, JEX, TRAP.
REQ-012 Any output not listed for a state SHALL be 0 in that state.
REQ-013 FETCH: alusrcb=01; pcwrite=irwrite=1 on its final cycle only.
REQ-014 DECODE: alusrcb=11. Next state by op: 100011/101011->MEMADR, 000000->RTYPEEX, 000100->BEQEX, 000101->BNEEX, 001000->ADDIEX, 001101->ORIEX, 000010->JEX, any other->illegal handling.
REQ-015 MEMADR: alusrca=1, alusrcb=10; next MEMRD if op=100011, else MEMWR.
REQ-016 MEMRD: iord=1, next MEMWB. MEMWB: memtoreg=1, regwrite=1, next FETCH.
REQ-017 MEMWR: iord=1, memwrite=1 on every cycle of the state; next FETCH.
REQ-018 RTYPEEX: alusrca=1, aluop=10, next ALUWB. ALUWB: regdst=1, regwrite=1, next FETCH.
REQ-019 BEQEX/BNEEX: alusrca=1, aluop=01, pcsrc=01, branch=01/10 respectively, next FETCH.
REQ-020 ADDIEX: alusrca=1, alusrcb=10, aluop=00. ORIEX: same with aluop=11, zeroext=1. Both go next to IMMWB, which has regwrite=1 and goes next to FETCH; zeroext SHALL be 0 in IMMWB.
REQ-021 JEX: pcsrc=10, pcwrite=1, next FETCH.
REQ-022 FETCH, MEMRD and MEMWR SHALL each last exactly MEM_WAIT+1 cycles, timed by a wait counter.
- The counter clears on state entry.
- The state advances when count==MEM_WAIT.
REQ-023 All other states SHALL last exactly 1 cycle.
- Latency in cycles with W=MEM_WAIT: lw 5+2W; sw 4+2W; R-type/addi/ori 4+W; beq/bne/j 3+W.
REQ-024 instr_done SHALL pulse on the final cycle of MEMWB, MEMWR, ALUWB, IMMWB, BEQEX, BNEEX and JEX.
REQ-025 op SHALL be sampled only in DECODE and MEMADR; changes of op in other states SHALL have no effect.
REQ-026 All outputs SHALL be Moore outputs, decoded from state and counter only.

Reset
REQ-027 Asserting reset at any time, including mid-instruction or mid-wait, SHALL force FETCH, clear the counter and clear trap without waiting for a clock edge.
REQ-028 During reset all outputs SHALL be 0 except alusrcb=01, which is the FETCH value.
REQ-029 After release, the first rising edge SHALL count as FETCH cycle 0.

Configuration
REQ-030 When macro MC_CTRL_TRAP_EN is defined, an illegal op in DECODE SHALL enter TRAP.
- TRAP holds all strobes at 0 and asserts trap=1.
- TRAP is left only by reset.
REQ-031 When MC_CTRL_TRAP_EN is undefined, an illegal op SHALL return to FETCH as a no-op.
- In that case instr_done pulses in DECODE, trap is tied to 0, and TRAP is unreachable.

Structure
REQ-032 Package mips_mc_pkg SHALL hold:
- the state enum typedef (4-bit);
- the opcode localparams;
- the aluop, pcsrc and branch code constants.
REQ-033 The wait counter SHALL be a sub-module mc_wait_cnt, parametrised by WAIT_W, with inputs clear/target and output done.

Verification
REQ-034 MEM_WAIT=0, op=100011 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; instr_done on cycle 5; memtoreg=regwrite=1 in cycle 5.
REQ-035 MEM_WAIT=2, op=101011 -> FETCH 3 cycles with irwrite only on the 3rd; MEMWR 3 cycles with memwrite=1 throughout; total 8 cycles.
REQ-036 op=000101 then op=000100 -> BNEEX with branch=10, pcsrc=01; then BEQEX with branch=01; each takes 3 cycles.
REQ-037 op=001101 -> ORIEX with aluop=11, zeroext=1; IMMWB with regwrite=1, zeroext=0.
REQ-038 op=111111 -> with MC_CTRL_TRAP_EN: trap=1 and stuck until reset; without it: back to FETCH, trap=0.
REQ-039 Reset asserted mid-MEMRD with MEM_WAIT=3 -> immediate FETCH and counter=0; after release the next instruction completes normally.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared state, opcode and control-code definitions for mips_mc_ctrl
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        BNEEX   = 4'd9,
        ADDIEX  = 4'd10,
        ORIEX   = 4'd11,
        IMMWB   = 4'd12,
        JEX     = 4'd13,
        TRAP    = 4'd14
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;

    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_ADDI) || (op == OP_ORI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_wait_cnt.sv
// rtl/mc_wait_cnt.sv - wait-state counter; done while count equals target, saturates there
module mc_wait_cnt #(
    parameter int WAIT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [WAIT_W-1:0] target,
    output logic              done
);

    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;

    assign done = (cnt_q == target);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multicycle MIPS control FSM with memory wait states
// Optional illegal-opcode trap state enabled by macro MC_CTRL_TRAP_EN.
module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic       zeroext,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [1:0] branch,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       trap
);

    localparam logic [WAIT_W-1:0] WAIT_TGT = WAIT_W'(MEM_WAIT);

    state_t state_q;
    state_t state_d;
    logic   wait_done;
    logic   cnt_clear;

    // Counter restarts whenever the state changes and idles outside wait states.
    assign cnt_clear = (state_d != state_q) || !is_wait_state(state_q);

    mc_wait_cnt #(
        .WAIT_W(WAIT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .target(WAIT_TGT),
        .done  (wait_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (wait_done) state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_BNE:       state_d = BNEEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_ORI:       state_d = ORIEX;
                    OP_J:         state_d = JEX;
`ifdef MC_CTRL_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (wait_done) state_d = MEMWB;
            MEMWB:   state_d = FETCH;
            MEMWR:   if (wait_done) state_d = FETCH;
            RTYPEEX: state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BEQEX:   state_d = FETCH;
            BNEEX:   state_d = FETCH;
            ADDIEX:  state_d = IMMWB;
            ORIEX:   state_d = IMMWB;
            IMMWB:   state_d = FETCH;
            JEX:     state_d = FETCH;
`ifdef MC_CTRL_TRAP_EN
            TRAP:    state_d = TRAP;
`else
            TRAP:    state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
    end

    assign state = state_q;

    always_comb begin
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        zeroext    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;
        branch     = BR_NONE;
        instr_done = 1'b0;
        trap       = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                // With MEM_WAIT=0 the counter reads done while reset holds it, so mask the strobes.
                pcwrite = wait_done && !reset;
                irwrite = wait_done && !reset;
            end
            DECODE: begin
                alusrcb = 2'b11;
`ifndef MC_CTRL_TRAP_EN
                instr_done = !is_legal_op(op);
`endif
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = wait_done;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            BEQEX, BNEEX: begin
                alusrca    = 1'b1;
                aluop      = ALUOP_SUB;
                pcsrc      = PCSRC_ALUOUT;
                branch     = (state_q == BEQEX) ? BR_EQ : BR_NE;
                instr_done = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_ADD;
            end
            ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_OR;
                zeroext = 1'b1;
            end
            IMMWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            JEX: begin
                pcsrc      = PCSRC_JUMP;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            TRAP: begin
`ifdef MC_CTRL_TRAP_EN
                trap = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - self-checking bench for mips_mc_ctrl against a per-instruction sequence model
module tb_mips_mc_ctrl;
    import mips_mc_pkg::*;

    localparam int W = 2;
`ifdef MC_CTRL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [8:0] S_PCW  = 9'h100;
    localparam logic [8:0] S_IRW  = 9'h080;
    localparam logic [8:0] S_RW   = 9'h040;
    localparam logic [8:0] S_MW   = 9'h020;
    localparam logic [8:0] S_IORD = 9'h010;
    localparam logic [8:0] S_SRCA = 9'h008;
    localparam logic [8:0] S_RDST = 9'h004;
    localparam logic [8:0] S_M2R  = 9'h002;
    localparam logic [8:0] S_ZX   = 9'h001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       pcwrite, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, zeroext;
    logic [1:0] alusrcb, pcsrc, aluop, branch;
    logic [3:0] state;
    logic       instr_done, trap;

    int vectors = 0;
    int miscompares = 0;
    int lat_cnt = 0;
    int last_lat = 0;
    int done_cnt = 0;
    int exp_done = 0;

    logic [22:0] exp_q[$];
    logic [22:0] seq_q[$];
    bit          smp_q[$];
    logic [5:0]  legal_ops[8];

    always #5 clk = ~clk;

    mips_mc_ctrl #(.MEM_WAIT(W), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op),
        .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .iord(iord), .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg), .zeroext(zeroext),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .branch(branch),
        .state(state), .instr_done(instr_done), .trap(trap)
    );

    function automatic logic [22:0] rec(input logic [3:0] s, input logic [8:0] st, input logic [1:0] b,
                                        input logic [1:0] pc, input logic [1:0] ao, input logic [1:0] br,
                                        input logic d, input logic t);
        return {s, st, b, pc, ao, br, d, t};
    endfunction

    function automatic bit legal(input logic [5:0] o);
        for (int i = 0; i < 8; i++) if (legal_ops[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add(input logic [22:0] r, input bit s);
        seq_q.push_back(r);
        smp_q.push_back(s);
    endtask

    // Expected per-cycle outputs for one whole instruction, FETCH through its last cycle.
    task automatic build(input logic [5:0] o);
        seq_q.delete();
        smp_q.delete();
        for (int i = 0; i <= W; i++)
            add(rec(FETCH, (i == W) ? (S_PCW | S_IRW) : 9'h0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0), 1'b0);
        add(rec(DECODE, 9'h0, 2'b11, 2'b00, 2'b00, 2'b00, !legal(o) && !TRAP_EN, 1'b0), 1'b1);
        if (o == OP_LW || o == OP_SW) begin
            add(rec(MEMADR, S_SRCA, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0), 1'b1);
            for (int i = 0; i <= W; i++) begin
                if (o == OP_LW)
                    add(rec(MEMRD, S_IORD, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0), 1'b0);
                else
                    add(rec(MEMWR, S_IORD | S_MW, 2'b00, 2'b00, 2'b00, 2'b00, i == W, 1'b0), 1'b0);
            end
            if (o == OP_LW) add(rec(MEMWB, S_M2R | S_RW, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0), 1'b0);
        end else if (o == OP_RTYPE) begin
            add(rec(RTYPEEX, S_SRCA, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0), 1'b0);
            add(rec(ALUWB, S_RDST | S_RW, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0), 1'b0);
        end else if (o == OP_BEQ || o == OP_BNE) begin
            add(rec((o == OP_BEQ) ? BEQEX : BNEEX, S_SRCA, 2'b00, 2'b01, 2'b01,
                    (o == OP_BEQ) ? 2'b01 : 2'b10, 1'b1, 1'b0), 1'b0);
        end else if (o == OP_ADDI || o == OP_ORI) begin
            add(rec((o == OP_ADDI) ? ADDIEX : ORIEX, (o == OP_ORI) ? (S_SRCA | S_ZX) : S_SRCA,
                    2'b10, 2'b00, (o == OP_ORI) ? 2'b11 : 2'b00, 2'b00, 1'b0, 1'b0), 1'b0);
            add(rec(IMMWB, S_RW, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0), 1'b0);
        end else if (o == OP_J) begin
            add(rec(JEX, S_PCW, 2'b00, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0), 1'b0);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; asserts reset mid-cycle and releases it two edges later.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("reset_state_immediate", state, FETCH);
        chk("reset_alusrcb", alusrcb, 2'b01);
        chk("reset_pcwrite", pcwrite, 0);
        chk("reset_trap", trap, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] o);
        build(o);
        for (int i = 0; i < seq_q.size(); i++) begin
            op = smp_q[i] ? o : 6'($urandom);
            exp_q.push_back(seq_q[i]);
            @(posedge clk);
            #1;
        end
        if (!legal(o) && TRAP_EN) begin
            for (int i = 0; i < 4; i++) begin
                op = 6'($urandom);
                exp_q.push_back(rec(TRAP, 9'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
                @(posedge clk);
                #1;
            end
            chk("trap_stuck", trap, 1);
            do_reset();
        end else begin
            exp_done++;
        end
    endtask

    always @(negedge clk) begin
        logic [22:0] act;
        logic [22:0] ex;
        bit          have;
        act = {state, pcwrite, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, zeroext,
               alusrcb, pcsrc, aluop, branch, instr_done, trap};
        have = 1'b1;
        if (reset) ex = rec(FETCH, 9'h0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        else if (exp_q.size() > 0) ex = exp_q.pop_front();
        else have = 1'b0;
        if (have) begin
            vectors++;
            if (act !== ex) begin
                miscompares++;
                $display("FAIL cycle t=%0t actual=%h expected=%h (state %0d vs %0d)",
                         $time, act, ex, act[22:19], ex[22:19]);
            end
        end
        if (reset) begin
            lat_cnt = 0;
        end else begin
            lat_cnt++;
            if (instr_done) begin
                last_lat = lat_cnt;
                lat_cnt = 0;
                done_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] o;
        legal_ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J};
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(OP_LW);   chk("lat_lw", last_lat, 9);
        run_instr(OP_SW);   chk("lat_sw", last_lat, 8);
        run_instr(OP_BNE);  chk("lat_bne", last_lat, 5);
        run_instr(OP_BEQ);  chk("lat_beq", last_lat, 5);
        run_instr(OP_ORI);  chk("lat_ori", last_lat, 6);
        run_instr(OP_ADDI); chk("lat_addi", last_lat, 6);
        run_instr(OP_RTYPE); chk("lat_rtype", last_lat, 6);
        run_instr(OP_J);    chk("lat_j", last_lat, 5);
        run_instr(6'b111111);

        // Abort a load in the middle of its MEMRD wait.
        build(OP_LW);
        for (int i = 0; i < W + 4; i++) begin
            op = smp_q[i] ? OP_LW : 6'($urandom);
            exp_q.push_back(seq_q[i]);
            @(posedge clk);
            #1;
        end
        chk("abort_in_memrd", state, MEMRD);
        do_reset();
        run_instr(OP_LW);   chk("lat_lw_after_abort", last_lat, 9);

        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 9);
            o = (r < 8) ? legal_ops[r] : 6'($urandom);
            run_instr(o);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("instr_done_count", done_cnt, exp_done);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
